// File: rtl/router_psum_read.sv
// Streams stored partial sums from the psum GLB into the PE cluster, one word per column per trigger.
// Optional PSUM_READ_ZERO_INIT_EN: iteration 0 sends zeros instead of reading the GLB.
module router_psum_read #(
  parameter int DATA_BITWIDTH     = 16,
  parameter int ADDR_BITWIDTH_GLB = 10,
  parameter int X_dim             = 3,
  parameter int kernel_size       = 3,
  parameter int act_size          = 5,
  parameter int PSUM_READ_ADDR    = 500,
  localparam int NUM_ITER = act_size - kernel_size + 1,
  localparam int COL_W    = (X_dim > 1) ? $clog2(X_dim) : 1,
  localparam int ITER_W   = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         read_psum_ctrl,
  output logic                         read_req_glb_psum,
  output logic [ADDR_BITWIDTH_GLB-1:0] r_addr_glb_psum,
  input  logic [DATA_BITWIDTH-1:0]     r_data_glb_psum,
  output logic [DATA_BITWIDTH-1:0]     w_data_spad_psum,
  output logic                         load_en_spad_psum,
  input  logic                         load_ready_spad_psum,
  output logic [COL_W-1:0]             col_idx_psum,
  output logic [ITER_W-1:0]            iter_idx,
  output logic                         read_psum_done
);

  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, SEND, DONE} state_t;

  state_t                       state_q, state_d;
  logic [COL_W-1:0]             col_q, col_d;
  logic [ITER_W-1:0]            iter_q, iter_d;
  logic [DATA_BITWIDTH-1:0]     hold_q, hold_d;
  logic [ADDR_BITWIDTH_GLB-1:0] addr_q, addr_d;
  logic                         zero_iter;

`ifdef PSUM_READ_ZERO_INIT_EN
  assign zero_iter = (iter_q == '0);
`else
  assign zero_iter = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    iter_d  = iter_q;
    hold_d  = hold_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: if (read_psum_ctrl) begin
        state_d = ISSUE;
        addr_d  = ADDR_BITWIDTH_GLB'(PSUM_READ_ADDR + int'(iter_q) * X_dim);
      end
      ISSUE:   state_d = CAPTURE;
      CAPTURE: begin
        hold_d  = zero_iter ? '0 : r_data_glb_psum;
        state_d = SEND;
      end
      SEND: if (load_ready_spad_psum) begin
        if (col_q == COL_W'(X_dim - 1)) begin
          state_d = DONE;
        end else begin
          state_d = ISSUE;
          col_d   = col_q + COL_W'(1);
          // Address for the next column is registered now so r_addr is stable in ISSUE.
          addr_d  = ADDR_BITWIDTH_GLB'(PSUM_READ_ADDR + int'(iter_q) * X_dim + int'(col_q) + 1);
        end
      end
      DONE: begin
        state_d = IDLE;
        col_d   = '0;
        iter_d  = (iter_q == ITER_W'(NUM_ITER - 1)) ? '0 : iter_q + ITER_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      iter_q  <= '0;
      hold_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      iter_q  <= iter_d;
      hold_q  <= hold_d;
      addr_q  <= addr_d;
    end
  end

  assign read_req_glb_psum = (state_q == ISSUE) && !zero_iter;
  assign r_addr_glb_psum   = addr_q;
  assign w_data_spad_psum  = hold_q;
  assign load_en_spad_psum = (state_q == SEND);
  assign col_idx_psum      = col_q;
  assign iter_idx          = iter_q;
  assign read_psum_done    = (state_q == DONE);

endmodule

// File: tb/tb_router_psum_read.sv
// Scoreboard bench for router_psum_read: directed triggers, ready stalls, ignored triggers, mid-transfer reset.
module tb_router_psum_read;
  logic        clk = 1'b0;
  logic        reset, read_psum_ctrl, load_ready_spad_psum;
  logic        read_req_glb_psum, load_en_spad_psum, read_psum_done;
  logic [9:0]  r_addr_glb_psum;
  logic [15:0] r_data_glb_psum = '0;
  logic [15:0] w_data_spad_psum;
  logic [1:0]  col_idx_psum, iter_idx;

  router_psum_read dut (
    .clk(clk), .reset(reset), .read_psum_ctrl(read_psum_ctrl),
    .read_req_glb_psum(read_req_glb_psum), .r_addr_glb_psum(r_addr_glb_psum),
    .r_data_glb_psum(r_data_glb_psum), .w_data_spad_psum(w_data_spad_psum),
    .load_en_spad_psum(load_en_spad_psum), .load_ready_spad_psum(load_ready_spad_psum),
    .col_idx_psum(col_idx_psum), .iter_idx(iter_idx), .read_psum_done(read_psum_done)
  );

  always #5 clk = ~clk;

  typedef struct { int data; int col; } word_t;
  word_t word_q[$];
  int    addr_q[$];
  int    checks = 0, errors = 0, cyc = 0, exp_iter = 0;
  logic [15:0] mem [0:1023];

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (read_req_glb_psum) r_data_glb_psum <= mem[r_addr_glb_psum];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: compares every GLB request and every presented word against the queues.
  initial forever begin
    @(negedge clk); #1;
    if (reset) begin
      if (read_req_glb_psum) begin
        if (addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req addr=%0d expected none", r_addr_glb_psum);
        end else chk("r_addr", int'(r_addr_glb_psum), addr_q.pop_front());
      end
      if (load_en_spad_psum) begin
        chk("req_while_held", int'(read_req_glb_psum), 0);
        if (word_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word data=%0d expected none", w_data_spad_psum);
        end else begin
          chk("w_data", int'(w_data_spad_psum), word_q[0].data);
          chk("col_idx", int'(col_idx_psum), word_q[0].col);
          if (load_ready_spad_psum) void'(word_q.pop_front());
        end
      end
    end
  end

  task automatic push_iter(input int it, input int ncol);
    for (int c = 0; c < ncol; c++) begin
      word_t w;
      w.col = c;
      w.data = 10 + it * 3 + c;
`ifdef PSUM_READ_ZERO_INIT_EN
      if (it == 0) w.data = 0; else addr_q.push_back(500 + it * 3 + c);
`else
      addr_q.push_back(500 + it * 3 + c);
`endif
      word_q.push_back(w);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_read_req"}, int'(read_req_glb_psum), 0);
    chk({tag, "_r_addr"},   int'(r_addr_glb_psum), 0);
    chk({tag, "_w_data"},   int'(w_data_spad_psum), 0);
    chk({tag, "_load_en"},  int'(load_en_spad_psum), 0);
    chk({tag, "_col_idx"},  int'(col_idx_psum), 0);
    chk({tag, "_iter_idx"}, int'(iter_idx), 0);
    chk({tag, "_done"},     int'(read_psum_done), 0);
  endtask

  task automatic trig(input int stall_n, input bit glitch, input int exp_lat);
    int c0, lat, stall_left, act;
    bit stalled, g1;
    lat = -1; stall_left = 0; stalled = 0; g1 = 0;
    push_iter(exp_iter, 3);
    @(negedge clk); read_psum_ctrl = 1; c0 = cyc;
    @(negedge clk); read_psum_ctrl = 0;
    for (int k = 0; k < 60; k++) begin
      if (read_psum_done) begin
        lat = cyc - c0;
        if (glitch) read_psum_ctrl = 1;
        break;
      end
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) load_ready_spad_psum = 1;
      end else if (!stalled && stall_n > 0 && load_en_spad_psum && col_idx_psum == 2'd1) begin
        load_ready_spad_psum = 0; stalled = 1; stall_left = stall_n;
      end
      if (glitch) begin
        if (read_psum_ctrl) read_psum_ctrl = 0;
        else if (!g1 && load_en_spad_psum) begin read_psum_ctrl = 1; g1 = 1; end
      end
      @(negedge clk);
    end
    chk("done_latency", lat, exp_lat);
    @(negedge clk); read_psum_ctrl = 0;
    exp_iter = (exp_iter + 1) % 3;
    chk("iter_idx", int'(iter_idx), exp_iter);
    if (glitch) begin
      act = 0;
      repeat (6) begin
        @(negedge clk);
        if (load_en_spad_psum || read_req_glb_psum || read_psum_done) act++;
      end
      chk("idle_after_ignored_trigger", act, 0);
    end
  endtask

  task automatic reset_in_capture();
    bit found;
    word_t w;
    found = 0;
`ifdef PSUM_READ_ZERO_INIT_EN
    if (exp_iter != 0) begin addr_q.push_back(500 + exp_iter * 3); addr_q.push_back(501 + exp_iter * 3); end
`else
    addr_q.push_back(500 + exp_iter * 3); addr_q.push_back(501 + exp_iter * 3);
`endif
    w.col = 0; w.data = 10 + exp_iter * 3;
    word_q.push_back(w);
    @(negedge clk); read_psum_ctrl = 1;
    @(negedge clk); read_psum_ctrl = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (load_en_spad_psum == 0 && col_idx_psum == 2'd1) begin found = 1; break; end
    end
    chk("found_col1_issue", int'(found), 1);
    @(negedge clk);
    reset = 0;
    #1 chk_reset_outputs("async_rst");
    word_q.delete(); addr_q.delete();
    @(negedge clk); reset = 1;
    exp_iter = 0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'hDEAD;
    for (int i = 0; i < 9; i++) mem[500 + i] = 16'(10 + i);
    reset = 0; read_psum_ctrl = 0; load_ready_spad_psum = 1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1;
    trig(0, 0, 10);   // iter 0: 10,11,12
    trig(0, 0, 10);   // iter 1: 13,14,15
    trig(0, 0, 10);   // iter 2: 16,17,18, iter wraps
    trig(4, 0, 14);   // iter 0 again, col 1 stalled four cycles
    trig(0, 1, 10);   // iter 1 with triggers during SEND and DONE
    trig(0, 0, 10);   // iter 2
    trig(0, 0, 10);   // iter 0
    reset_in_capture();
    chk("iter_after_reset", int'(iter_idx), 0);
    trig(0, 0, 10);   // restarts at 500
    repeat (3) @(negedge clk);
    chk("words_left", word_q.size(), 0);
    chk("addrs_left", addr_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/router_psum_read.md
# router_psum_read

Reads previously stored partial sums from the psum GLB bank and streams them into the PE cluster as incoming psums for the next accumulation pass. It is the reader counterpart of `router_psum`, which writes PE cluster outputs into the psum GLB. It sits between `GLB_cluster` (psum read port) and `PE_cluster` (psum input load path). One trigger fetches one psum per PE column for the current output row, then advances the row index.

## Interface
Parameters:
- DATA_BITWIDTH, 16, psum word width
- ADDR_BITWIDTH_GLB, 10, GLB address width
- X_dim, 3, PE columns, which is also the number of psums per trigger
- kernel_size, 3, filter height/width
- act_size, 5, activation height/width
- PSUM_READ_ADDR, 500, GLB base address of the psum region

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- read_psum_ctrl  in  1  start pulse from control unit; sampled only in IDLE
- read_req_glb_psum  out  1  GLB read request
- r_addr_glb_psum  out  ADDR_BITWIDTH_GLB  GLB read address
- r_data_glb_psum  in  DATA_BITWIDTH  GLB read data, valid the cycle after read_req
- w_data_spad_psum  out  DATA_BITWIDTH  psum to PE cluster
- load_en_spad_psum  out  1  w_data_spad_psum valid
- load_ready_spad_psum  in  1  PE cluster accepts the word when high together with load_en
- col_idx_psum  out  $clog2(X_dim) (min 1)  destination column of the current word
- iter_idx  out  $clog2(NUM_ITER) (min 1)  current output-row iteration
- read_psum_done  out  1  one-cycle pulse after the last column is accepted

## Operation
- NUM_ITER = act_size − kernel_size + 1 (3 with defaults).
- FSM states and transitions:
  - IDLE → ISSUE on read_psum_ctrl=1.
  - ISSUE → CAPTURE unconditionally.
  - CAPTURE → SEND unconditionally.
  - SEND stays in SEND while load_ready_spad_psum=0.
  - SEND → ISSUE on handshake if col < X_dim−1; SEND → DONE on handshake if col = X_dim−1.
  - DONE → IDLE unconditionally.
- ISSUE:
  - read_req_glb_psum=1.
  - r_addr_glb_psum = PSUM_READ_ADDR + iter*X_dim + col, truncated to ADDR_BITWIDTH_GLB bits (wraps modulo 2^ADDR_BITWIDTH_GLB).
- CAPTURE: r_data_glb_psum is latched into the hold register.
- SEND:
  - load_en_spad_psum=1. w_data_spad_psum = hold register; col_idx_psum = col.
  - Data, col and enable stay stable until the handshake (load_en & load_ready).
  - On handshake, col increments.
- DONE:
  - read_psum_done=1 for one cycle; col clears to 0.
  - iter increments, wrapping NUM_ITER−1 → 0.
- read_psum_ctrl outside IDLE (including the DONE cycle) is ignored and not queued.
- read_req_glb_psum is high only in ISSUE. The block never issues a second read while a word is held.

## Timing
- Reset values: read_req_glb_psum=0, r_addr_glb_psum=0, w_data_spad_psum=0, load_en_spad_psum=0, col_idx_psum=0, iter_idx=0, read_psum_done=0, state=IDLE.
- Reset asserted mid-transfer aborts immediately: outputs return to reset values and iter returns to 0.
- Trigger sampled at edge T gives ISSUE in cycle T+1. The first load_en appears in cycle T+3.
- With ready held high, each word takes 3 cycles. X_dim=3 gives read_psum_done in cycle T+10.
- Each ready-low cycle in SEND adds exactly one cycle.
- Outputs are registered. None depends combinationally on load_ready_spad_psum.

## Configuration
- PSUM_READ_ZERO_INIT_EN:
  - Defined: when iter=0, the block issues no GLB read (read_req stays 0). It sends zeros for all X_dim columns with the same SEND/DONE sequencing. ISSUE and CAPTURE still occupy their cycles, so timing is identical. This gives a zero initial psum for the first row.
  - Undefined: every iteration reads the GLB, including iter 0.

## Test plan
- Reset, then GLB[500..508]=10..18; pulse trigger with ready=1 → words 10,11,12 on cols 0,1,2; addresses 500,501,502; done at T+10; iter_idx=1.
- Two more triggers → words 13,14,15, then 16,17,18; after the third done, iter_idx wraps to 0. A fourth trigger reads address 500 again.
- Hold ready=0 for 4 cycles on col 1 → data 11 and col 1 stable throughout; no new read_req; done delayed by exactly 4 cycles.
- Pulse read_psum_ctrl again during SEND and during DONE → ignored; exactly 3 words are transferred, and the next IDLE trigger starts normally.
- Assert reset during CAPTURE of col 1, iter 1 → all outputs return to 0 asynchronously. The next trigger reads 500,501,502.
- With PSUM_READ_ZERO_INIT_EN defined: first trigger → three zero words, read_req never high. Second trigger → 13,14,15 from addresses 503..505.
